// File: rtl/counter_4bit_monitor.sv
// Passive monitor for an up/down counter bus: locks onto the count direction,
// flags illegal steps, legal wraps and reversals, and keeps saturating tallies.
module counter_4bit_monitor #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             dir,
  output logic             step_err,
  output logic             wrap,
  output logic             rev,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, TRACK_UP, TRACK_DOWN} state_e;

  localparam logic [WIDTH-1:0] VMAX = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;
  logic             rev_q, rev_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] p_inc, p_dec;
  logic             is_up, is_dn, is_hold;
  logic             err_hit, wrap_hit;

  always_comb begin
    p_inc        = prev_q + 1'b1;
    p_dec        = prev_q - 1'b1;
    is_up        = (cnt_in == p_inc);
    is_dn        = (cnt_in == p_dec);
    is_hold      = (cnt_in == prev_q);
    err_hit      = 1'b0;
    wrap_hit     = 1'b0;
    state_d      = state_q;
    prev_d       = prev_q;
    dir_d        = dir_q;
    rev_d        = 1'b0;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;

    if (clr) begin
      state_d      = UNLOCKED;
      wrap_count_d = '0;
      err_count_d  = '0;
    end else if (en) begin
      prev_d = cnt_in;
      unique case (state_q)
        UNLOCKED: state_d = ACQUIRE;
        ACQUIRE: begin
          if (is_up) begin
            state_d = TRACK_UP;
            dir_d   = 1'b1;
          end else if (is_dn) begin
            state_d = TRACK_DOWN;
            dir_d   = 1'b0;
          end else if (!is_hold) begin
            err_hit = 1'b1;
          end
        end
        TRACK_UP: begin
          // The +1 path is tested first, so a max->0 step here is a wrap while
          // a 0->max step falls to the reversal branch and never wraps.
          if (is_up) begin
            wrap_hit = (prev_q == VMAX);
          end else if (is_dn) begin
            state_d = TRACK_DOWN;
            dir_d   = 1'b0;
            rev_d   = 1'b1;
          end else if (is_hold) begin
            err_hit = (ALLOW_HOLD == 0);
          end else begin
            err_hit = 1'b1;
            state_d = ACQUIRE;
          end
        end
        TRACK_DOWN: begin
          if (is_dn) begin
            wrap_hit = (prev_q == '0);
          end else if (is_up) begin
            state_d = TRACK_UP;
            dir_d   = 1'b1;
            rev_d   = 1'b1;
          end else if (is_hold) begin
            err_hit = (ALLOW_HOLD == 0);
          end else begin
            err_hit = 1'b1;
            state_d = ACQUIRE;
          end
        end
        default: state_d = UNLOCKED;
      endcase
      if (err_hit && err_count_q != CMAX)   err_count_d  = err_count_q + 1'b1;
      if (wrap_hit && wrap_count_q != CMAX) wrap_count_d = wrap_count_q + 1'b1;
    end

    step_err_d = err_hit;
    wrap_d     = wrap_hit;
    locked_d   = (state_d == TRACK_UP) || (state_d == TRACK_DOWN);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      prev_q       <= '0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      step_err_q   <= 1'b0;
      wrap_q       <= 1'b0;
      rev_q        <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      step_err_q   <= step_err_d;
      wrap_q       <= wrap_d;
      rev_q        <= rev_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign dir        = dir_q;
  assign step_err   = step_err_q;
  assign wrap       = wrap_q;
  assign rev        = rev_q;
  assign wrap_count = wrap_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_counter_4bit_monitor.sv
// Directed bench for counter_4bit_monitor: default build, a hold-tolerant build
// and a 2-bit-counter build all watch the same stimulus.
module tb_counter_4bit_monitor;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cnt_in = 4'd0;

  logic       locked, dir, step_err, wrap, rev;
  logic [7:0] wrap_count, err_count;
  logic       h_locked, h_dir, h_step_err, h_wrap, h_rev;
  logic [7:0] h_wrap_count, h_err_count;
  logic       s_locked, s_dir, s_step_err, s_wrap, s_rev;
  logic [1:0] s_wrap_count, s_err_count;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  counter_4bit_monitor dut (
    .CLK(CLK), .reset(reset), .en(en), .clr(clr), .cnt_in(cnt_in),
    .locked(locked), .dir(dir), .step_err(step_err), .wrap(wrap), .rev(rev),
    .wrap_count(wrap_count), .err_count(err_count));

  counter_4bit_monitor #(.ALLOW_HOLD(1)) dut_h (
    .CLK(CLK), .reset(reset), .en(en), .clr(clr), .cnt_in(cnt_in),
    .locked(h_locked), .dir(h_dir), .step_err(h_step_err), .wrap(h_wrap), .rev(h_rev),
    .wrap_count(h_wrap_count), .err_count(h_err_count));

  counter_4bit_monitor #(.CNT_W(2)) dut_s (
    .CLK(CLK), .reset(reset), .en(en), .clr(clr), .cnt_in(cnt_in),
    .locked(s_locked), .dir(s_dir), .step_err(s_step_err), .wrap(s_wrap), .rev(s_rev),
    .wrap_count(s_wrap_count), .err_count(s_err_count));

  // Present one enabled sample, then look at outputs just after the edge.
  task automatic smp(input logic [3:0] v);
    @(negedge CLK);
    en = 1'b1; clr = 1'b0; cnt_in = v;
    @(posedge CLK);
    #1;
    en = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge CLK);
    en = 1'b1; clr = 1'b1; cnt_in = 4'd5;
    @(posedge CLK);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b0 || wrap_count !== 8'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset flags=%b wc=%0d ec=%0d exp=00000/0/0",
               {locked, dir, step_err, wrap, rev}, wrap_count, err_count);
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] v;
    logic [3:0] e;
    do_clr();
    for (int i = 0; i < 15; i++) begin
      v = 4'(3 + i);
      smp(v);
      e = {(i >= 1), 1'b0, (v == 4'd0), 1'b0};
      checks++;
      if ({locked, step_err, wrap, rev} !== e || (i >= 1 && dir !== 1'b1)) begin
        failures++;
        $display("FAIL up_wrap v=%0d flags=%b dir=%b exp=%b/1", v, {locked, step_err, wrap, rev}, dir, e);
      end
    end
    checks++;
    if (wrap_count !== 8'd1 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL up_wrap_counts wc=%0d ec=%0d exp=1/0", wrap_count, err_count);
    end
  endtask

  task automatic test_reversal();
    do_clr();
    smp(4'd5); smp(4'd6); smp(4'd7);
    smp(4'd6);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b10001) begin
      failures++;
      $display("FAIL rev_pulse flags=%b exp=10001", {locked, dir, step_err, wrap, rev});
    end
    smp(4'd5);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b10000 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL rev_after flags=%b ec=%0d exp=10000/0", {locked, dir, step_err, wrap, rev}, err_count);
    end
  endtask

  task automatic test_down_wrap();
    do_clr();
    smp(4'd2); smp(4'd1); smp(4'd0);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b10000) begin
      failures++;
      $display("FAIL down_pre flags=%b exp=10000", {locked, dir, step_err, wrap, rev});
    end
    smp(4'd15);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b10010 || wrap_count !== 8'd1) begin
      failures++;
      $display("FAIL down_wrap flags=%b wc=%0d exp=10010/1", {locked, dir, step_err, wrap, rev}, wrap_count);
    end
    smp(4'd14);
    smp(4'd15);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b11001) begin
      failures++;
      $display("FAIL rev_up flags=%b exp=11001", {locked, dir, step_err, wrap, rev});
    end
    smp(4'd0);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b11010 || wrap_count !== 8'd2) begin
      failures++;
      $display("FAIL up_wrap2 flags=%b wc=%0d exp=11010/2", {locked, dir, step_err, wrap, rev}, wrap_count);
    end
    smp(4'd15);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b10001 || wrap_count !== 8'd2) begin
      failures++;
      $display("FAIL rev_at_boundary flags=%b wc=%0d exp=10001/2", {locked, dir, step_err, wrap, rev}, wrap_count);
    end
  endtask

  task automatic test_step_err();
    do_clr();
    smp(4'd8); smp(4'd9);
    smp(4'd12);
    checks++;
    if ({locked, step_err, wrap, rev} !== 4'b0100 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL jump flags=%b ec=%0d exp=0100/1", {locked, step_err, wrap, rev}, err_count);
    end
    smp(4'd13);
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b11000 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL relock flags=%b ec=%0d exp=11000/1", {locked, dir, step_err, wrap, rev}, err_count);
    end
  endtask

  task automatic test_hold();
    do_clr();
    smp(4'd2); smp(4'd3);
    smp(4'd3);
    checks++;
    if ({locked, dir, step_err} !== 3'b111 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL hold_strict flags=%b ec=%0d exp=111/1", {locked, dir, step_err}, err_count);
    end
    checks++;
    if ({h_locked, h_dir, h_step_err} !== 3'b110 || h_err_count !== 8'd0) begin
      failures++;
      $display("FAIL hold_allowed flags=%b ec=%0d exp=110/0", {h_locked, h_dir, h_step_err}, h_err_count);
    end
    smp(4'd4);
    checks++;
    if ({locked, step_err, h_locked, h_step_err} !== 4'b1010 || err_count !== 8'd1 || h_err_count !== 8'd0) begin
      failures++;
      $display("FAIL hold_after flags=%b ec=%0d hec=%0d exp=1010/1/0",
               {locked, step_err, h_locked, h_step_err}, err_count, h_err_count);
    end
  endtask

  task automatic test_enable();
    do_clr();
    smp(4'd7); smp(4'd8);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      en = 1'b0; cnt_in = 4'd3;
      @(posedge CLK);
      #1;
      checks++;
      if ({locked, dir, step_err, wrap, rev} !== 5'b11000) begin
        failures++;
        $display("FAIL en_low flags=%b exp=11000", {locked, dir, step_err, wrap, rev});
      end
    end
    smp(4'd9);
    checks++;
    if ({locked, dir, step_err} !== 3'b110 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL en_resume flags=%b ec=%0d exp=110/0", {locked, dir, step_err}, err_count);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] seq [6] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9};
    logic [1:0] es;
    do_clr();
    for (int i = 0; i < 6; i++) begin
      smp(seq[i]);
      es = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (s_step_err !== (i != 0) || s_err_count !== es || s_locked !== 1'b0) begin
        failures++;
        $display("FAIL sat i=%0d err=%b ec=%0d lk=%b exp=%b/%0d/0", i, s_step_err, s_err_count, s_locked, (i != 0), es);
      end
    end
    checks++;
    if (err_count !== 8'd5) begin
      failures++;
      $display("FAIL wide_count ec=%0d exp=5", err_count);
    end
    do_clr();
    checks++;
    if ({s_locked, s_step_err, s_wrap, s_rev} !== 4'b0 || s_err_count !== 2'd0 || err_count !== 8'd0
        || {locked, step_err} !== 2'b0) begin
      failures++;
      $display("FAIL clr_en flags=%b sec=%0d ec=%0d exp=0000/0/0", {s_locked, s_step_err, s_wrap, s_rev},
               s_err_count, err_count);
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    smp(4'd14); smp(4'd15); smp(4'd0);
    checks++;
    if ({locked, dir, wrap} !== 3'b111 || wrap_count !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset flags=%b wc=%0d exp=111/1", {locked, dir, wrap}, wrap_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({locked, dir, step_err, wrap, rev} !== 5'b0 || wrap_count !== 8'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset flags=%b wc=%0d ec=%0d exp=00000/0/0",
               {locked, dir, step_err, wrap, rev}, wrap_count, err_count);
    end
    @(negedge CLK);
    reset = 1'b1;
    smp(4'd10);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reacquire_first locked=%b exp=0", locked);
    end
    smp(4'd11);
    checks++;
    if ({locked, dir, step_err} !== 3'b110) begin
      failures++;
      $display("FAIL reacquire flags=%b exp=110", {locked, dir, step_err});
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_reversal();
    test_down_wrap();
    test_step_err();
    test_hold();
    test_enable();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_4bit_monitor.md
# counter_4bit_monitor

Passive observer placed on the output bus of a 4-bit up/down counter. Each enabled cycle it samples the count, infers counting direction, checks that every step is a legal ±1 move (modulo 2^WIDTH), and tracks wrap-arounds and step errors. It reports lock status, direction, one-cycle event pulses and saturating event counters for use by benches and on-chip self-check logic.

## Interface
- WIDTH, 4, width of the observed count bus
- CNT_W, 8, width of the wrap and error counters
- ALLOW_HOLD, 0, 1 = repeated value while locked is legal; 0 = it is a step error
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  sample enable; the count is evaluated only on cycles with en=1
- clr  in  1  synchronous clear of counters and lock state
- cnt_in  in  WIDTH  observed counter value
- locked  out  1  high in TRACK_UP / TRACK_DOWN
- dir  out  1  1 = counting up, 0 = counting down; valid when locked=1
- step_err  out  1  one-cycle pulse on an illegal step
- wrap  out  1  one-cycle pulse on a legal wrap (max->0 up, 0->max down)
- rev  out  1  one-cycle pulse on a legal direction reversal
- wrap_count  out  CNT_W  saturating number of wraps
- err_count  out  CNT_W  saturating number of step errors

## Operation
- Internal register prev (WIDTH) holds the last sampled value; s = cnt_in. All arithmetic on prev±1 is modulo 2^WIDTH.
- States: UNLOCKED, ACQUIRE, TRACK_UP, TRACK_DOWN.
- UNLOCKED, en=1: prev<=s; go ACQUIRE. No flags.
- ACQUIRE, en=1: s==prev+1 -> TRACK_UP, dir<=1. s==prev-1 -> TRACK_DOWN, dir<=0. s==prev -> stay, no error. Any other value -> step_err, err_count+1, stay. prev<=s in every case.
- TRACK_UP, en=1: s==prev+1 is legal; if prev==max and s==0, also pulse wrap and increment wrap_count. s==prev-1 -> TRACK_DOWN, dir<=0, pulse rev, no error. s==prev -> legal if ALLOW_HOLD=1; otherwise step_err and stay in TRACK_UP. Any other value -> step_err, err_count+1, go ACQUIRE (lock lost). prev<=s.
- TRACK_DOWN: mirror image of TRACK_UP. Wrap is prev==0 with s==max. s==prev+1 -> TRACK_UP with rev.
- A reversal step that is also a wrap boundary, such as TRACK_UP with prev=0 and s=max, counts as a reversal only. No wrap pulse is generated.
- Counters saturate at 2^CNT_W-1 and never roll over.
- en=0: state, prev, dir and counters hold; all pulses are 0.
- clr=1: state<=UNLOCKED, both counters<=0, pulses 0, prev and dir hold. clr has priority over en.

## Timing
- Reset (reset=0, async): state UNLOCKED, prev=0, locked=0, dir=0, step_err=0, wrap=0, rev=0, wrap_count=0, err_count=0. Deassertion is synchronised externally, and the first evaluation happens on the first rising edge with reset=1.
- All outputs are registered. A sample presented before edge k produces its flags and counter updates in the cycle after edge k, giving 1-cycle latency.
- Pulses last exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- locked rises in the cycle after the first legal ±1 step following UNLOCKED or ACQUIRE. From UNLOCKED, lock needs at least two enabled samples.
- If reset asserts mid-stream, everything returns to reset values immediately. After reset, lock must be re-acquired.

## Test plan
- Up-count sequence 3,4,…,15,0,1 with en=1 -> locked=1 from the cycle after sample 4, dir=1, a single wrap pulse after sample 0, wrap_count=1, err_count=0.
- Up-count 5,6,7, then down-count 6,5 -> rev pulse after sample 6 (second occurrence), dir=0, locked stays 1, err_count=0.
- Locked up-count 8,9, then jump to 12 -> step_err pulse, err_count=1, locked=0. Next sample 13 -> locked=1 again.
- ALLOW_HOLD=0: sequence 2,3,3,4 -> one step_err on the repeated 3, and locked stays 1. ALLOW_HOLD=1: same sequence gives no error.
- CNT_W=2 with 5 forced errors -> err_count saturates at 3. Then clr=1 with en=1 in the same cycle -> counters 0, locked=0, no flags.
- Assert reset=0 mid-sequence, asynchronously between edges -> all outputs go to 0 immediately. After release, the sequence 10,11 re-locks with dir=1.
